// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch redirect/flush,
// instruction/data memory wait handling and a saturating stall counter.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] pc_plus4,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [31:0] pc_next,
  output logic        stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [15:0] cnt_q;
  logic        lu;
  logic        flush_mode;

  assign lu = ex_mem_read & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) |
               (id_use_rs2 & (id_rs2 == ex_rd)));

  // A FLUSH-bound exit from MEM_WAIT still owes the wrong-path discard.
  assign flush_mode = (state_q == FLUSH) |
                      ((state_q == MEM_WAIT) & pend_q);

  always_comb begin
    pc_next     = pc_plus4;
    stall       = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = state_q;
    pend_d      = pend_q;
    if (reset) begin
      state_d = RUN;
      pend_d  = 1'b0;
    end else if (!dmem_ready) begin
      stall       = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
      state_d     = MEM_WAIT;
      if (state_q == FLUSH)
        pend_d = 1'b1;
      else if (state_q == RUN)
        pend_d = 1'b0;
    end else begin
      pend_d = 1'b0;
      if (flush_mode) begin
        ifid_flush = 1'b1;
        stall      = ~imem_ready;
        state_d    = (state_q == MEM_WAIT) ? FLUSH : RUN;
      end else begin
        state_d = RUN;
        if (ex_branch_taken) begin
          pc_next    = ex_branch_target;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = FLUSH;
        end else if (lu) begin
          stall      = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (!imem_ready) begin
          stall      = 1'b1;
          ifid_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (stall && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign state        = state_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_mem_read, ex_branch_taken;
  logic [31:0] ex_branch_target, pc_plus4;
  logic        imem_ready, dmem_ready;
  logic [31:0] pc_next;
  logic        stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .pc_plus4         (pc_plus4),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .pc_next          (pc_next),
    .stall            (stall),
    .ifid_stall       (ifid_stall),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .pipe_freeze      (pipe_freeze),
    .state            (state),
    .stall_cycles     (stall_cycles)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control outputs packed {stall,ifid_stall,ifid_flush,idex_flush,freeze}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, stall, ifid_stall, ifid_flush,
                idex_flush, pipe_freeze}, {27'd0, exp});
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0;
    ex_branch_target = 32'h0;
    imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pc_plus4 = 32'h0000_1004;
    idle();
    reset = 1;
    set_lu();
    ex_branch_taken = 1; ex_branch_target = 32'h40;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_cnt", {16'd0, stall_cycles}, 32'd0);
    chk_ctl("rst_ctl", 5'b00000);
    check("rst_pc", pc_next, 32'h1004);
    tick();
    chk_ctl("rst_ctl_clk", 5'b00000);
    check("rst_state_clk", {30'd0, state}, 32'd0);
    reset = 0;
    idle();

    // load to x0 never stalls
    tick();
    set_lu(); ex_rd = 0; id_rs2 = 0;
    #1 chk_ctl("lu_x0", 5'b00000);
    tick();
    check("lu_x0_cnt", {16'd0, stall_cycles}, 32'd0);

    // load-use on rs2, one bubble
    set_lu();
    #1 chk_ctl("lu_rs2", 5'b11010);
    check("lu_rs2_st", {30'd0, state}, 32'd0);
    tick();
    idle();
    #1 chk_ctl("lu_after", 5'b00000);
    check("lu_cnt", {16'd0, stall_cycles}, 32'd1);

    // rs1 match but source unused: no hazard
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
    #1 chk_ctl("lu_unused", 5'b00000);
    tick();
    idle();

    // taken branch then FLUSH then RUN
    ex_branch_taken = 1; ex_branch_target = 32'h100;
    #1 check("br_pc", pc_next, 32'h100);
    chk_ctl("br_ctl", 5'b00110);
    tick();
    idle();
    set_lu(); ex_branch_taken = 1; ex_branch_target = 32'h300;
    #1 check("fl_state", {30'd0, state}, 32'd1);
    chk_ctl("fl_ctl", 5'b00100);
    check("fl_pc", pc_next, 32'h1004);
    tick();
    idle();
    #1 check("fl_exit", {30'd0, state}, 32'd0);

    // imem wait in RUN
    imem_ready = 0;
    #1 chk_ctl("imem", 5'b10100);
    check("imem_pc", pc_next, 32'h1004);
    tick();
    idle();
    #1 check("imem_cnt", {16'd0, stall_cycles}, 32'd2);

    // dmem wait while in FLUSH, 3 cycles
    ex_branch_taken = 1; ex_branch_target = 32'h100;
    tick();
    idle();
    dmem_ready = 0;
    #1 chk_ctl("fl_dm0", 5'b11001);
    tick();
    check("mw_st1", {30'd0, state}, 32'd2);
    chk_ctl("mw_ctl1", 5'b11001);
    tick();
    check("mw_st2", {30'd0, state}, 32'd2);
    tick();
    dmem_ready = 1;
    #1 check("mw_st3", {30'd0, state}, 32'd2);
    chk_ctl("mw_exit", 5'b00100);
    tick();
    check("mw_fl", {30'd0, state}, 32'd1);
    chk_ctl("mw_fl_ctl", 5'b00100);
    tick();
    check("mw_run", {30'd0, state}, 32'd0);
    check("mw_cnt", {16'd0, stall_cycles}, 32'd5);

    // branch vs dmem wait in same cycle: freeze wins
    ex_branch_taken = 1; ex_branch_target = 32'h200;
    dmem_ready = 0;
    #1 check("bd_pc", pc_next, 32'h1004);
    chk_ctl("bd_ctl", 5'b11001);
    tick();
    check("bd_state", {30'd0, state}, 32'd2);
    dmem_ready = 1;
    #1 check("bd_pc2", pc_next, 32'h200);
    chk_ctl("bd_ctl2", 5'b00110);
    tick();
    idle();
    #1 check("bd_fl", {30'd0, state}, 32'd1);
    check("bd_cnt", {16'd0, stall_cycles}, 32'd6);
    tick();

    // reset mid-MEM_WAIT
    dmem_ready = 0;
    tick();
    check("rmw_st", {30'd0, state}, 32'd2);
    reset = 1;
    #1 check("rmw_async", {30'd0, state}, 32'd0);
    chk_ctl("rmw_ctl", 5'b00000);
    check("rmw_cnt", {16'd0, stall_cycles}, 32'd0);
    tick();
    reset = 0;
    dmem_ready = 1;
    tick();
    check("rmw_run", {30'd0, state}, 32'd0);

    // saturation
    set_lu();
    repeat (65534) @(posedge clk);
    #1 check("sat_fffe", {16'd0, stall_cycles}, 32'hFFFE);
    repeat (4466) @(posedge clk);
    #1 check("sat_ffff", {16'd0, stall_cycles}, 32'hFFFF);
    chk_ctl("sat_ctl", 5'b11010);
    #1 reset = 1;
    #1 check("sat_rst", {16'd0, stall_cycles}, 32'd0);
    reset = 0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
